// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED display constants, ring state enum and diameter defaults
package oled_pkg;

  typedef enum logic [1:0] {
    RING_OFF    = 2'd0,
    RING_MANUAL = 2'd1,
    RING_ANIM   = 2'd2
  } ring_state_e;

  localparam int unsigned OLED_W  = 96;
  localparam int unsigned OLED_H  = 64;
  localparam int unsigned OLED_CX = OLED_W / 2;
  localparam int unsigned OLED_CY = OLED_H / 2;

  localparam logic [15:0] COL_BLACK = 16'h0000;
  localparam logic [15:0] COL_WHITE = 16'hFFFF;
  localparam logic [15:0] COL_RED   = 16'hF800;
  localparam logic [15:0] COL_GREEN = 16'h07E0;
  localparam logic [15:0] COL_BLUE  = 16'h001F;

  localparam int unsigned RING_DIA_INIT  = 30;
  localparam int unsigned RING_DIA_MIN   = 10;
  localparam int unsigned RING_DIA_MAX   = 50;
  localparam int unsigned RING_STEP      = 5;
  localparam int unsigned RING_THICKNESS = 5;

endpackage

// File: rtl/ring_ctrl_if.sv
// rtl/ring_ctrl_if.sv - frame/button inputs and committed ring outputs of the ring controller
interface ring_ctrl_if;

  logic       frame_begin;
  logic       press_c;
  logic       press_u;
  logic       press_d;
  logic       ring_active;
  logic [7:0] outer_dia;
  logic [7:0] inner_dia;
  logic       anim_on;

  // Debouncers and the OLED driver side.
  modport master (
    output frame_begin, press_c, press_u, press_d,
    input  ring_active, outer_dia, inner_dia, anim_on
  );

  // The ring controller itself.
  modport slave (
    input  frame_begin, press_c, press_u, press_d,
    output ring_active, outer_dia, inner_dia, anim_on
  );

endinterface

// File: rtl/ring_dia_stepper.sv
// rtl/ring_dia_stepper.sv - one bounded diameter step up or down, combinational
module ring_dia_stepper #(
  parameter int unsigned DIA_MIN = 10,
  parameter int unsigned DIA_MAX = 50,
  parameter int unsigned STEP    = 5
) (
  input  logic [7:0] dia_i,
  input  logic       up_i,
  output logic [7:0] dia_o,
  output logic       blocked_o
);

  logic [8:0] sum_up;
  logic [8:0] sum_dn;

  // Nine-bit sums so the bound comparisons never wrap; a blocked step keeps the diameter.
  always_comb begin
    sum_up    = {1'b0, dia_i} + 9'(STEP);
    sum_dn    = {1'b0, dia_i} - 9'(STEP);
    blocked_o = 1'b0;
    dia_o     = dia_i;
    if (up_i) begin
      blocked_o = (sum_up > 9'(DIA_MAX));
      if (!blocked_o) dia_o = sum_up[7:0];
    end else begin
      blocked_o = ({1'b0, dia_i} < (9'(DIA_MIN) + 9'(STEP)));
      if (!blocked_o) dia_o = sum_dn[7:0];
    end
  end

endmodule

// File: rtl/ring_ctrl.sv
// rtl/ring_ctrl.sv - frame-synchronous ring enable, manual diameter stepping and pulse animation
module ring_ctrl
  import oled_pkg::*;
#(
  parameter int unsigned DIA_INIT    = RING_DIA_INIT,
  parameter int unsigned DIA_MIN     = RING_DIA_MIN,
  parameter int unsigned DIA_MAX     = RING_DIA_MAX,
  parameter int unsigned STEP        = RING_STEP,
  parameter int unsigned THICKNESS   = RING_THICKNESS,
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned PEND_MAX    = 3
) (
  input  logic         clk,
  input  logic         reset,
  ring_ctrl_if.slave   bus
);

  if (DIA_MIN < THICKNESS) begin : g_chk_thick
    $error("ring_ctrl: DIA_MIN must be at least THICKNESS");
  end
  if ((DIA_INIT < DIA_MIN) || (DIA_INIT > DIA_MAX)) begin : g_chk_init
    $error("ring_ctrl: DIA_INIT must lie within DIA_MIN..DIA_MAX");
  end
  if ((STEP == 0) || (((DIA_INIT - DIA_MIN) % STEP) != 0)) begin : g_chk_grid
    $error("ring_ctrl: DIA_INIT must sit on the STEP grid above DIA_MIN");
  end
  if ((DIA_MAX - DIA_MIN) < STEP) begin : g_chk_range
    $error("ring_ctrl: diameter range must hold at least one STEP");
  end
  if (ANIM_FRAMES < 1) begin : g_chk_anim
    $error("ring_ctrl: ANIM_FRAMES must be at least 1");
  end

  localparam logic signed [7:0] PMAX     = 8'(PEND_MAX);
  localparam logic [15:0]       CNT_LAST = 16'(ANIM_FRAMES - 1);

  ring_state_e        state_q, state_d;
  logic               req_c_q, req_c_d;
  logic signed [7:0]  pending_q, pending_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic               ring_active_q, ring_active_d;
  logic [7:0]         outer_q, outer_d;
  logic [7:0]         inner_q, inner_d;
  logic               anim_on_q, anim_on_d;

  logic               step_a_up;
  logic [7:0]         dia_a, dia_b;
  logic               blocked_a, blocked_b;
  logic signed [7:0]  delta, pend_base, pend_sum;

  // Manual mode steps toward the sign of pending; animation uses the sweep direction.
  assign step_a_up = (state_q == RING_MANUAL) ? (pending_q > 8'sd0) : dir_up_q;

  ring_dia_stepper #(.DIA_MIN(DIA_MIN), .DIA_MAX(DIA_MAX), .STEP(STEP)) u_step_a (
    .dia_i     (outer_q),
    .up_i      (step_a_up),
    .dia_o     (dia_a),
    .blocked_o (blocked_a)
  );

  // Reverse-direction step, used when the animation bounces off a bound.
  ring_dia_stepper #(.DIA_MIN(DIA_MIN), .DIA_MAX(DIA_MAX), .STEP(STEP)) u_step_b (
    .dia_i     (outer_q),
    .up_i      (~dir_up_q),
    .dia_o     (dia_b),
    .blocked_o (blocked_b)
  );

  // Next-state logic: everything visible only moves on frame_begin, presses accumulate any cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_up_d      = dir_up_q;
    ring_active_d = ring_active_q;
    outer_d       = outer_q;
    anim_on_d     = anim_on_q;
    pend_base     = pending_q;
    delta         = 8'sd0;

    // A press landing on frame_begin is kept for the following frame.
    req_c_d = (bus.frame_begin ? 1'b0 : req_c_q) | bus.press_c;

    if (state_q == RING_MANUAL) begin
      if (bus.press_u && !bus.press_d)      delta = 8'sd1;
      else if (bus.press_d && !bus.press_u) delta = -8'sd1;
    end

    if (bus.frame_begin) begin
      case (state_q)
        RING_OFF: begin
          if (req_c_q) begin
            state_d       = RING_MANUAL;
            ring_active_d = 1'b1;
          end
        end
        RING_MANUAL: begin
          if (req_c_q) begin
            state_d   = RING_ANIM;
            anim_on_d = 1'b1;
            cnt_d     = '0;
            dir_up_d  = 1'b1;
            pend_base = 8'sd0;
            delta     = 8'sd0;
          end else if (pending_q != 8'sd0) begin
            if (blocked_a) begin
              pend_base = 8'sd0;
            end else begin
              outer_d   = dia_a;
              pend_base = (pending_q > 8'sd0) ? pending_q - 8'sd1 : pending_q + 8'sd1;
            end
          end
        end
        RING_ANIM: begin
          if (req_c_q) begin
            state_d   = RING_MANUAL;
            anim_on_d = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!blocked_a) begin
              outer_d = dia_a;
            end else begin
              dir_up_d = ~dir_up_q;
              if (!blocked_b) outer_d = dia_b;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = RING_OFF;
        end
      endcase
    end

    pend_sum = pend_base + delta;
    if (pend_sum > PMAX)       pending_d = PMAX;
    else if (pend_sum < -PMAX) pending_d = -PMAX;
    else                       pending_d = pend_sum;

    inner_d = outer_d - 8'(THICKNESS);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RING_OFF;
      req_c_q       <= 1'b0;
      pending_q     <= 8'sd0;
      cnt_q         <= '0;
      dir_up_q      <= 1'b1;
      ring_active_q <= 1'b0;
      outer_q       <= 8'(DIA_INIT);
      inner_q       <= 8'(DIA_INIT - THICKNESS);
      anim_on_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_c_q       <= req_c_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      dir_up_q      <= dir_up_d;
      ring_active_q <= ring_active_d;
      outer_q       <= outer_d;
      inner_q       <= inner_d;
      anim_on_q     <= anim_on_d;
    end
  end

  assign bus.ring_active = ring_active_q;
  assign bus.outer_dia   = outer_q;
  assign bus.inner_dia   = inner_q;
  assign bus.anim_on     = anim_on_q;

endmodule

// File: tb/tb_ring_ctrl.sv
// tb/tb_ring_ctrl.sv - directed and randomized checks of ring_ctrl against a frame-level model
module tb_ring_ctrl;

  localparam int DIA_INIT = 30;
  localparam int DIA_MIN  = 10;
  localparam int DIA_MAX  = 50;
  localparam int STEP     = 5;
  localparam int THICK    = 5;
  localparam int AFRAMES  = 4;
  localparam int PMAX     = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  ring_ctrl_if bus ();

  ring_ctrl #(
    .DIA_INIT(DIA_INIT), .DIA_MIN(DIA_MIN), .DIA_MAX(DIA_MAX), .STEP(STEP),
    .THICKNESS(THICK), .ANIM_FRAMES(AFRAMES), .PEND_MAX(PMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = off, 1 = manual, 2 = animation.
  int m_mode, m_pend, m_dia, m_cnt;
  bit m_req, m_up;

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_dia = DIA_INIT; m_cnt = 0; m_req = 0; m_up = 1;
  endtask

  task automatic model_cycle(input bit r, input bit fb, input bit c, input bit u, input bit d);
    int delta;
    if (r) begin
      model_reset();
      return;
    end
    delta = (m_mode == 1) ? (int'(u) - int'(d)) : 0;
    if (fb) begin
      if (m_mode == 0) begin
        if (m_req) m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_req) begin
          m_mode = 2; m_pend = 0; m_cnt = 0; m_up = 1; delta = 0;
        end else if (m_pend > 0) begin
          if (m_dia + STEP <= DIA_MAX) begin m_dia += STEP; m_pend--; end
          else m_pend = 0;
        end else if (m_pend < 0) begin
          if (m_dia - STEP >= DIA_MIN) begin m_dia -= STEP; m_pend++; end
          else m_pend = 0;
        end
      end else begin
        if (m_req) m_mode = 1;
        else if (m_cnt == AFRAMES - 1) begin
          m_cnt = 0;
          if (m_up && m_dia + STEP > DIA_MAX) m_up = 0;
          else if (!m_up && m_dia - STEP < DIA_MIN) m_up = 1;
          m_dia = m_up ? m_dia + STEP : m_dia - STEP;
        end else m_cnt++;
      end
      m_req = c;
    end else begin
      m_req = m_req | c;
    end
    m_pend = m_pend + delta;
    if (m_pend > PMAX) m_pend = PMAX;
    if (m_pend < -PMAX) m_pend = -PMAX;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit fb, input bit c, input bit u, input bit d);
    @(negedge clk);
    reset = r; bus.frame_begin = fb; bus.press_c = c; bus.press_u = u; bus.press_d = d;
    @(posedge clk);
    model_cycle(r, fb, c, u, d);
    #1;
    chk("ring_active", {8'd0, bus.ring_active}, 9'(m_mode != 0));
    chk("anim_on",     {8'd0, bus.anim_on},     9'(m_mode == 2));
    chk("outer_dia",   {1'b0, bus.outer_dia},   9'(m_dia));
    chk("inner_dia",   {1'b0, bus.inner_dia},   9'(m_dia - THICK));
  endtask

  task automatic frame();
    tick(0, 1, 0, 0, 0);
  endtask

  initial begin
    bus.frame_begin = 0; bus.press_c = 0; bus.press_u = 0; bus.press_d = 0;
    model_reset();

    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rst_active", {8'd0, bus.ring_active}, 9'd0);
    chk("rst_outer", {1'b0, bus.outer_dia}, 9'd30);
    chk("rst_inner", {1'b0, bus.inner_dia}, 9'd25);
    chk("rst_anim", {8'd0, bus.anim_on}, 9'd0);

    tick(0, 0, 1, 0, 0);
    chk("off_before_frame", {8'd0, bus.ring_active}, 9'd0);
    frame();
    chk("on_after_frame", {8'd0, bus.ring_active}, 9'd1);
    chk("on_outer", {1'b0, bus.outer_dia}, 9'd30);

    tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
    chk("two_up_held", {1'b0, bus.outer_dia}, 9'd30);
    frame(); chk("up_f1", {1'b0, bus.outer_dia}, 9'd35);
    frame(); chk("up_f2", {1'b0, bus.outer_dia}, 9'd40);
    frame(); chk("up_f3", {1'b0, bus.outer_dia}, 9'd40);

    repeat (3) tick(0, 0, 0, 1, 0);
    frame(); frame(); chk("reach_max", {1'b0, bus.outer_dia}, 9'd50);
    frame(); chk("sat_clamped", {1'b0, bus.outer_dia}, 9'd50);
    tick(0, 0, 0, 1, 0); frame();
    chk("blocked_up", {1'b0, bus.outer_dia}, 9'd50);
    tick(0, 0, 0, 0, 1); frame();
    chk("cleared_then_down", {1'b0, bus.outer_dia}, 9'd45);

    tick(0, 0, 0, 1, 1); frame();
    chk("both_pressed", {1'b0, bus.outer_dia}, 9'd45);
    tick(0, 1, 0, 1, 0);
    chk("press_on_frame", {1'b0, bus.outer_dia}, 9'd45);
    frame(); chk("press_next_frame", {1'b0, bus.outer_dia}, 9'd50);

    repeat (8) begin tick(0, 0, 0, 0, 1); frame(); end
    chk("reach_min", {1'b0, bus.outer_dia}, 9'd10);
    tick(0, 0, 0, 0, 1); frame();
    chk("blocked_down", {1'b0, bus.outer_dia}, 9'd10);
    repeat (7) begin tick(0, 0, 0, 1, 0); frame(); end
    chk("back_to_45", {1'b0, bus.outer_dia}, 9'd45);

    tick(0, 0, 1, 0, 0); frame();
    chk("anim_entered", {8'd0, bus.anim_on}, 9'd1);
    chk("anim_entry_dia", {1'b0, bus.outer_dia}, 9'd45);
    repeat (3) frame();
    chk("anim_wait", {1'b0, bus.outer_dia}, 9'd45);
    frame(); chk("anim_step1", {1'b0, bus.outer_dia}, 9'd50);
    repeat (4) frame(); chk("anim_bounce_top", {1'b0, bus.outer_dia}, 9'd45);
    repeat (4) frame(); chk("anim_down", {1'b0, bus.outer_dia}, 9'd40);
    tick(0, 0, 0, 1, 0);
    repeat (24) frame(); chk("anim_at_min", {1'b0, bus.outer_dia}, 9'd10);
    repeat (4) frame(); chk("anim_bounce_bot", {1'b0, bus.outer_dia}, 9'd15);

    tick(0, 0, 1, 0, 0); frame();
    chk("back_manual", {8'd0, bus.anim_on}, 9'd0);
    chk("manual_held", {1'b0, bus.outer_dia}, 9'd15);
    tick(0, 0, 0, 1, 0); frame();
    chk("manual_up_again", {1'b0, bus.outer_dia}, 9'd20);

    tick(0, 0, 1, 0, 0); frame();
    repeat (5) frame();
    chk("anim_again", {1'b0, bus.outer_dia}, 9'd25);
    tick(1, 0, 0, 0, 0);
    chk("mid_rst_active", {8'd0, bus.ring_active}, 9'd0);
    chk("mid_rst_anim", {8'd0, bus.anim_on}, 9'd0);
    chk("mid_rst_outer", {1'b0, bus.outer_dia}, 9'd30);

    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 399) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
